neuron_mac_seq: RTL and testbench
=================================

# neuron_mac_seq

Sequential multiply-accumulate neuron. It is the parametrised successor of the two-input combinational neuron, generalised to N_INPUTS signed weights. Inputs are accepted as one packed vector per transaction and accumulated one term per clock, so a single multiplier is used. The result is rounded or truncated, clamped to [0, INT_MAX], and presented under a valid/ready handshake. It sits between neuron layers, and downstream neurons or the layer collector consume `out_data`.

## Interface
- `NEURON_LEVEL`, default 0: layer index, debug only.
- `NEURON_ID`, default 0: index inside layer, debug only.
- `INT_WIDTH`, default 8: activation width. Range [0, 2^INT_WIDTH) maps to real [0, 1).
- `N_INPUTS`, default 4: synapse count, ≥ 2.
- `WEIGHT_WIDTH`, default 12: signed weight width, two's complement. A value of 2^INT_WIDTH means 1.0.
- `WEIGHTS`, default 0: packed `[N_INPUTS*WEIGHT_WIDTH-1:0]`. Weight i is at `[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  block can accept a vector.
- `in_data`  in  N_INPUTS*INT_WIDTH  unsigned activations. Input i is at `[i*INT_WIDTH +: INT_WIDTH]`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  INT_WIDTH  clamped activation.
- `busy`  out  1  state is not IDLE.

## Operation
- State machine: IDLE, ACC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: register `in_data`, set acc=0, set idx=0, go to ACC.
- ACC:
  - Each cycle: acc += zext(x[idx]) * w[idx], then idx++.
  - When idx==N_INPUTS-1, the same edge registers `out_data` = sat(acc_next), sets `out_valid`=1, and goes to DONE.
- DONE:
  - `out_valid`=1.
  - `out_data` holds stable until `out_ready`=1.
  - On `out_ready`=1 the handshake completes: `out_valid`=0, go to IDLE.
- `in_ready` is 0 in ACC and DONE. `in_valid` asserted outside IDLE is ignored and does not fault.
- `in_data` may change after acceptance with no effect on the result.
- Arithmetic widths:
  - Product width P = INT_WIDTH+WEIGHT_WIDTH+1, signed.
  - ACC_WIDTH = P + clog2(N_INPUTS). No accumulator overflow is possible.
- sat(a):
  - s = a >>> INT_WIDTH (arithmetic shift).
  - If s<0, result is 0.
  - Else if s>INT_MAX, result is INT_MAX.
  - Else result is s[INT_MSB:0].

## Timing
- Reset values, applied asynchronously while `rst`=0:
  - state=IDLE, acc=0, idx=0.
  - `out_valid`=0, `out_data`=0.
  - `in_ready`=1, `busy`=0.
- Latency: the accept edge is E0. `out_valid` rises at edge E0+N_INPUTS.
- Throughput: with `out_ready` tied high, one result per N_INPUTS+2 cycles.
- `in_ready` and `busy` decode combinationally from the registered state. There is no combinational path from `in_valid` or `out_ready` to any output.
- Reset asserted mid-ACC or mid-DONE:
  - The transaction is discarded and no `out_valid` pulse appears.
  - After `rst` deasserts, `in_ready`=1 on the first cycle.
- Deassertion of `rst` is synchronised externally and is not handled here.

## Configuration
- Macro `NEURON_ROUND_EN` selects the shift inside sat().
- Defined: round-half-up. s = (a + 2^(INT_WIDTH-1)) >>> INT_WIDTH. The addition is done at ACC_WIDTH+1 bits, and the clamp is applied afterwards.
- Undefined: truncation toward −∞, plain `>>>`.
- Latency and handshake are identical in both builds.

## Structure
- Package `neuron_pkg` holds:
  - typedef enum `neuron_state_t` {IDLE, ACC, DONE}.
  - function `clog2`.
  - function `acc_width(INT_WIDTH, WEIGHT_WIDTH, N_INPUTS)`, shared by all neuron variants.
- Sub-module `neuron_saturate`: purely combinational scale, round and clamp from ACC_WIDTH to INT_WIDTH, parameterised by INT_WIDTH and ACC_WIDTH. The `NEURON_ROUND_EN` option lives here only.

## Test plan
- Sum within range. Setup: INT_WIDTH=4, N=3, WEIGHTS={16,16,-8}. Stimulus: in={4,4,0}. Response: `out_data`=8, `out_valid` rises at edge E0+3.
- Positive overflow. Same weights, in={15,15,0}. Sum=480, s=30, so `out_data`=15 (INT_MAX).
- Negative clamp. Same weights, in={0,0,15}. Sum=-120, so `out_data`=0.
- Rounding option. WEIGHTS={8,0,0}, in={1,0,0}. `out_data`=0 without `NEURON_ROUND_EN`, `out_data`=1 with it.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 with new data.
  - Response: `out_data` stays stable, `in_ready`=0, and the second vector is not accepted until one cycle after the `out_ready` handshake.
- Reset mid-ACC. Pulse `rst` low at E0+1. Response: no `out_valid` appears, outputs return to reset values, and the next vector produces the correct result.

Source files
------------

// File: rtl/neuron_pkg.sv
//  +--------------------------------------------------------------------+
//  | Package   : neuron_pkg                                             |
//  | Purpose   : Shared types and width helpers for the neuron family.  |
//  |             neuron_state_t  - handshake/accumulate state encoding  |
//  |             clog2           - ceiling log2 for constant sizing     |
//  |             acc_width       - accumulator width for a MAC neuron   |
//  | Revision  : 1.0 - initial release                                  |
//  +--------------------------------------------------------------------+
`default_nettype none

package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } neuron_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Signed product of a zero-extended activation and a signed weight,
  // plus enough headroom to sum n_inputs of them without overflow.
  function automatic int acc_width(input int int_width,
                                   input int weight_width,
                                   input int n_inputs);
    return int_width + weight_width + 1 + clog2(n_inputs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_saturate.sv
//  +--------------------------------------------------------------------+
//  | Module    : neuron_saturate                                        |
//  | Purpose   : Combinational scale/round/clamp of a signed            |
//  |             accumulator down to an unsigned activation.            |
//  |             Scaling drops INT_WIDTH fraction bits, then clamps to  |
//  |             [0, 2^INT_WIDTH-1].                                    |
//  | Macro     : NEURON_ROUND_EN - round half up instead of truncating  |
//  |             toward minus infinity.                                 |
//  | Ports     : i_acc  [ACC_WIDTH] signed accumulator                  |
//  |             o_data [INT_WIDTH] clamped activation                  |
//  | Revision  : 1.0 - initial release                                  |
//  +--------------------------------------------------------------------+
`default_nettype none

module neuron_saturate #(
  parameter int INT_WIDTH = 8,
  parameter int ACC_WIDTH = 23
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic        [INT_WIDTH-1:0] o_data
);

  // One extra bit so the rounding addend can never wrap the accumulator.
  localparam logic signed [ACC_WIDTH:0] c_int_max =
    ((ACC_WIDTH+1)'(1) << INT_WIDTH) - (ACC_WIDTH+1)'(1);

  logic signed [ACC_WIDTH:0] w_pre;
  logic signed [ACC_WIDTH:0] w_shift;

  always_comb begin
    w_pre = {i_acc[ACC_WIDTH-1], i_acc};
`ifdef NEURON_ROUND_EN
    w_pre = w_pre + ((ACC_WIDTH+1)'(1) << (INT_WIDTH - 1));
`endif
    w_shift = w_pre >>> INT_WIDTH;

    if (w_shift < 0) begin
      o_data = '0;
    end else if (w_shift > c_int_max) begin
      o_data = '1;
    end else begin
      o_data = w_shift[INT_WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_mac_seq.sv
//  +--------------------------------------------------------------------+
//  | Module    : neuron_mac_seq                                         |
//  | Purpose   : Sequential multiply-accumulate neuron. One packed      |
//  |             input vector per transaction, one MAC term per clock,  |
//  |             result scaled/clamped and offered on valid/ready.      |
//  | Macro     : NEURON_ROUND_EN (in neuron_saturate) - round half up.  |
//  | Ports     : clk        rising-edge clock                           |
//  |             rst        asynchronous reset, active low              |
//  |             in_valid   / in_ready  input vector handshake          |
//  |             in_data    [N_INPUTS*INT_WIDTH] unsigned activations   |
//  |             out_valid  / out_ready result handshake                |
//  |             out_data   [INT_WIDTH] clamped activation              |
//  |             busy       state is not IDLE                           |
//  | Revision  : 1.0 - initial release                                  |
//  +--------------------------------------------------------------------+
`default_nettype none

module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int NEURON_LEVEL = 0,
  parameter int NEURON_ID    = 0,
  parameter int INT_WIDTH    = 8,
  parameter int N_INPUTS     = 4,
  parameter int WEIGHT_WIDTH = 12,
  parameter logic [N_INPUTS*WEIGHT_WIDTH-1:0] WEIGHTS = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_INPUTS*INT_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_WIDTH-1:0]          out_data,
  output logic                          busy
);

  localparam int c_prod_w = INT_WIDTH + WEIGHT_WIDTH + 1;
  localparam int c_acc_w  = acc_width(INT_WIDTH, WEIGHT_WIDTH, N_INPUTS);
  localparam int c_idx_w  = clog2(N_INPUTS);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_INPUTS - 1);

  // Layer/neuron indices exist only to tell instances apart when debugging;
  // they still get sanity-checked at elaboration together with N_INPUTS.
  generate
    if (N_INPUTS < 2 || NEURON_LEVEL < 0 || NEURON_ID < 0) begin : g_bad_cfg
      $error("neuron_mac_seq: invalid configuration");
    end
  endgenerate

  neuron_state_t r_state;
  neuron_state_t w_state_next;

  logic [N_INPUTS*INT_WIDTH-1:0] r_x;
  logic signed [c_acc_w-1:0]     r_acc;
  logic [c_idx_w-1:0]            r_idx;
  logic                          r_out_valid;
  logic [INT_WIDTH-1:0]          r_out_data;

  logic                          w_accept;
  logic                          w_last;
  logic [INT_WIDTH-1:0]          w_x_sel;
  logic [WEIGHT_WIDTH-1:0]       w_w_sel;
  logic signed [c_prod_w-1:0]    w_x_ext;
  logic signed [c_prod_w-1:0]    w_w_ext;
  logic signed [c_prod_w-1:0]    w_prod;
  logic signed [c_acc_w-1:0]     w_acc_next;
  logic [INT_WIDTH-1:0]          w_sat;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- next state / decoded outputs ----------------
  // in_ready and busy decode from r_state only, so no input reaches an
  // output combinationally.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b1;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ACC;
        end
      end
      ACC: begin
        if (r_idx == c_last_idx) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------- single shared multiplier ----------------
  always_comb begin
    w_x_sel    = r_x[r_idx*INT_WIDTH +: INT_WIDTH];
    w_w_sel    = WEIGHTS[r_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    // Activations are unsigned: zero-extend; weights sign-extend.
    w_x_ext    = c_prod_w'({1'b0, w_x_sel});
    w_w_ext    = c_prod_w'($signed(w_w_sel));
    w_prod     = w_x_ext * w_w_ext;
    w_acc_next = r_acc + c_acc_w'(w_prod);
  end

  neuron_saturate #(
    .INT_WIDTH (INT_WIDTH),
    .ACC_WIDTH (c_acc_w)
  ) u_sat (
    .i_acc  (w_acc_next),
    .o_data (w_sat)
  );

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x         <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_accept) begin
        r_x   <= in_data;
        r_acc <= '0;
        r_idx <= '0;
      end
      if (r_state == ACC) begin
        r_acc <= w_acc_next;
        r_idx <= r_idx + c_idx_w'(1);
      end
      // The final term is folded in on the same edge that publishes the
      // result, so saturation works on w_acc_next rather than r_acc.
      if (w_last) begin
        r_out_data  <= w_sat;
        r_out_valid <= 1'b1;
      end
      if (r_state == DONE && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_seq.sv
//  +--------------------------------------------------------------------+
//  | Module    : tb_neuron_mac_seq                                      |
//  | Purpose   : Directed self-checking bench for neuron_mac_seq with   |
//  |             INT_WIDTH=4, N_INPUTS=3, weights {16,16,-8}, plus a    |
//  |             second instance with weights {8,0,0} for rounding.     |
//  |             Expected results follow NEURON_ROUND_EN when defined.  |
//  | Revision  : 1.0 - initial release                                  |
//  +--------------------------------------------------------------------+
`default_nettype none

module tb_neuron_mac_seq;

  localparam int c_int_w = 4;
  localparam int c_n     = 3;
  localparam int c_w_w   = 12;
  // weight i at [i*12 +: 12]: w0=16, w1=16, w2=-8
  localparam logic [c_n*c_w_w-1:0] c_weights   = {12'hFF8, 12'd16, 12'd16};
  // w0=8, w1=0, w2=0
  localparam logic [c_n*c_w_w-1:0] c_weights_r = {12'd0, 12'd0, 12'd8};

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [c_n*c_int_w-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [c_int_w-1:0]     out_data;
  logic                   busy;

  logic                   in_valid2;
  logic                   in_ready2;
  logic [c_n*c_int_w-1:0] in_data2;
  logic                   out_valid2;
  logic                   out_ready2;
  logic [c_int_w-1:0]     out_data2;
  logic                   busy2;

  int n_checks;
  int n_fail;

  neuron_mac_seq #(
    .NEURON_LEVEL (1),
    .NEURON_ID    (0),
    .INT_WIDTH    (c_int_w),
    .N_INPUTS     (c_n),
    .WEIGHT_WIDTH (c_w_w),
    .WEIGHTS      (c_weights)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  neuron_mac_seq #(
    .NEURON_LEVEL (1),
    .NEURON_ID    (1),
    .INT_WIDTH    (c_int_w),
    .N_INPUTS     (c_n),
    .WEIGHT_WIDTH (c_w_w),
    .WEIGHTS      (c_weights_r)
  ) u_dut_round (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_data   (in_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2),
    .busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accept edge E0. Counts edges until
  // out_valid, checks latency and data, then completes the handshake.
  task automatic wait_result(input string tag, input logic [3:0] exp);
    int cyc;
    cyc = 0;
    check({tag, "_busy"}, busy, 1);
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 3);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_in_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_clr"}, out_valid, 0);
    check({tag, "_in_ready_idle"}, in_ready, 1);
  endtask

  task automatic run_vec(input string tag, input logic [11:0] x, input logic [3:0] exp);
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(tag, exp);
  endtask

  initial begin
    int cyc;
    int first_t;
    int second_t;
    int stray;
    logic [3:0] exp_round;

    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    in_valid2  = 1'b0;
    in_data2   = '0;
    out_ready2 = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid2", out_valid2, 0);
    rst = 1'b1;
    @(negedge clk);

    // ---- arithmetic: in-range, positive clamp, negative clamp ----
    run_vec("in_range", 12'h044, 4'd8);     // 64+64 = 128 -> 8
    run_vec("pos_clamp", 12'h0FF, 4'd15);   // 480 -> 30 -> 15
    run_vec("neg_clamp", 12'hF00, 4'd0);    // -120 -> 0
`ifdef NEURON_ROUND_EN
    exp_round = 4'd1;
`else
    exp_round = 4'd0;
`endif
    run_vec("half_lsb", 12'h101, exp_round); // 16-8 = 8 = 0.5 LSB

    // ---- rounding instance: weights {8,0,0}, in {1,0,0} ----
    in_valid2 = 1'b1;
    in_data2  = 12'h001;
    @(negedge clk);
    in_valid2 = 1'b0;
    cyc = 0;
    while (out_valid2 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("round_latency", cyc, 3);
    check("round_data", out_data2, exp_round);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    check("round_valid_clr", out_valid2, 0);

    // ---- backpressure: hold result while a new vector waits ----
    in_valid = 1'b1;
    in_data  = 12'h023;                     // 48+32 = 80 -> 5
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", cyc, 3);
    in_valid = 1'b1;
    in_data  = 12'h044;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", out_data, 5);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    // handshake edge returned to IDLE; the waiting vector is taken next edge
    check("bp_after_hs_valid", out_valid, 0);
    check("bp_after_hs_busy", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 12'hFFF;                     // must not disturb the result
    wait_result("bp_second", 4'd8);

    // ---- reset mid-ACC ----
    in_valid = 1'b1;
    in_data  = 12'h0FF;
    @(posedge clk);                          // E0
    #1 in_valid = 1'b0;
    @(posedge clk);                          // E0+1
    #1 rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    check("post_rst_in_ready", in_ready, 1);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    check("post_rst_no_valid", stray, 0);
    run_vec("post_rst_vec", 12'h044, 4'd8);

    // ---- throughput with out_ready tied high ----
    in_valid  = 1'b1;
    in_data   = 12'h044;
    out_ready = 1'b1;
    first_t   = -1;
    second_t  = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (first_t < 0) first_t = i;
        else if (second_t < 0) second_t = i;
      end
    end
    in_valid = 1'b0;
    check("tput_seen", (first_t >= 0 && second_t >= 0) ? 1 : 0, 1);
    check("tput_period", second_t - first_t, 5);
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    check("tput_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
